// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and constants for the L1 data cache controller:
//                FSM state encoding, line geometry and the line-fill request
//                code presented to data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 2;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int LINE_LSB   = $clog2(LINE_BYTES);

    // Memory decodes a line-fill as MemtoRegM[1:0] == 2'b11
    localparam logic [1:0] MEM_REQ_CODE = 2'b11;

    // Extract one 32-bit word from a cache line
    function automatic logic [WORD_W-1:0] line_word(
        input logic [LINE_W-1:0]   line,
        input logic [OFFSET_W-1:0] sel
    );
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Valid/tag/data storage for the direct-mapped data cache.
//                One combinational read port; one write port supporting a
//                full-line fill or a single-word store update.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int INDEX_W   = 6,
    parameter int TAG_W     = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_line,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic                line_we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [LINE_W-1:0]   wr_line,
    input  logic                word_we,
    input  logic [OFFSET_W-1:0] word_sel,
    input  logic [WORD_W-1:0]   wr_word
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_line  = r_data[rd_index];

    // Valid bits: cleared by reset, set when a line fill lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (line_we) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage: no reset, contents only matter once valid
    always_ff @(posedge clk) begin
        if (line_we) begin
            r_tag[wr_index]  <= wr_tag;
            r_data[wr_index] <= wr_line;
        end else if (word_we) begin
            r_data[wr_index][word_sel*WORD_W +: WORD_W] <= wr_word;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-through, no-write-allocate L1 data
//                cache controller. Loads hit combinationally; load misses
//                stall the pipeline through a REQ/FILL line-fill sequence;
//                stores go to memory in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int INDEX_W   = 6,
    parameter int TAG_W     = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ReadM,
    input  logic          WriteM,
    input  logic [31:0]   AddrM,
    input  logic [31:0]   WDataM,
    output logic [31:0]   RDataM,
    output logic          StallM,
    output logic          mem_RE,
    output logic          mem_WE,
    output logic [31:0]   mem_A,
    output logic [31:0]   mem_WD,
    input  logic          mem_READY,
    input  logic [127:0]  mem_RD
);

    localparam int c_TAG_LSB = LINE_LSB + INDEX_W;

    state_t               r_state;
    logic [31:0]          r_miss_addr;
    logic [1:0]           r_mem_cmd;

    logic [INDEX_W-1:0]   w_req_index;
    logic [INDEX_W-1:0]   w_fill_index;
    logic [INDEX_W-1:0]   w_wr_index;
    logic [TAG_W-1:0]     w_req_tag;
    logic [TAG_W-1:0]     w_fill_tag;
    logic [OFFSET_W-1:0]  w_offset;
    logic                 w_rd_valid;
    logic [TAG_W-1:0]     w_rd_tag;
    logic [LINE_W-1:0]    w_rd_line;
    logic                 w_idle;
    logic                 w_hit;
    logic                 w_load;
    logic                 w_load_miss;
    logic                 w_line_we;
    logic                 w_word_we;
    logic                 w_unused;

    // Address split for the pipeline request and the latched miss
    assign w_offset     = AddrM[LINE_LSB-1:2];
    assign w_req_index  = AddrM[c_TAG_LSB-1:LINE_LSB];
    assign w_req_tag    = AddrM[31:c_TAG_LSB];
    assign w_fill_index = r_miss_addr[c_TAG_LSB-1:LINE_LSB];
    assign w_fill_tag   = r_miss_addr[31:c_TAG_LSB];
    assign w_unused     = ^{AddrM[1:0], r_miss_addr[LINE_LSB-1:0]};

    // Hit detection; a simultaneous ReadM/WriteM is handled as a store
    assign w_idle      = (r_state == IDLE);
    assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_load      = ReadM && !WriteM;
    assign w_load_miss = w_idle && w_load && !w_hit;

    // Fills are dropped if reset arrives in the completing cycle
    assign w_line_we  = (r_state == FILL) && mem_READY && !rst;
    assign w_word_we  = w_idle && WriteM && w_hit && !rst;
    assign w_wr_index = w_line_we ? w_fill_index : w_req_index;

    assign StallM = !w_idle || w_load_miss;
    assign mem_RE = (r_mem_cmd == MEM_REQ_CODE);

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (w_req_index),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_line   (w_rd_line),
        .wr_index  (w_wr_index),
        .line_we   (w_line_we),
        .wr_tag    (w_fill_tag),
        .wr_line   (mem_RD),
        .word_we   (w_word_we),
        .word_sel  (w_offset),
        .wr_word   (WDataM)
    );

    // Miss FSM: latches the miss address, issues and holds the fill request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_mem_cmd   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load_miss) begin
                        r_miss_addr <= AddrM;
                        r_mem_cmd   <= MEM_REQ_CODE;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    // mem_READY may still be high from the previous fill
                    r_state <= FILL;
                end
                FILL: begin
                    if (mem_READY) begin
                        r_mem_cmd <= 2'b00;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_mem_cmd <= 2'b00;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Load data: only meaningful on an unstalled load hit, zero otherwise
    always_comb begin
        RDataM = '0;
        if (w_idle && w_load && w_hit) begin
            RDataM = line_word(w_rd_line, w_offset);
        end
    end

    // Memory-side mux: pass-through store in IDLE, line address while filling
    always_comb begin
        mem_WE = 1'b0;
        mem_A  = '0;
        mem_WD = '0;
        if (w_idle) begin
            if (WriteM) begin
                mem_WE = 1'b1;
                mem_A  = AddrM;
                mem_WD = WDataM;
            end
        end else begin
            mem_A = {r_miss_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Self-checking bench for dcache_ctrl. A transaction-level
//                model of the cache contents and the outstanding miss predicts
//                every output on every cycle; directed scenarios add literal
//                expectations on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          ReadM;
    logic          WriteM;
    logic [31:0]   AddrM;
    logic [31:0]   WDataM;
    logic [31:0]   RDataM;
    logic          StallM;
    logic          mem_RE;
    logic          mem_WE;
    logic [31:0]   mem_A;
    logic [31:0]   mem_WD;
    logic          mem_READY;
    logic [127:0]  mem_RD;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    dcache_ctrl #(
        .NUM_LINES (64),
        .INDEX_W   (6),
        .TAG_W     (22)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ReadM     (ReadM),
        .WriteM    (WriteM),
        .AddrM     (AddrM),
        .WDataM    (WDataM),
        .RDataM    (RDataM),
        .StallM    (StallM),
        .mem_RE    (mem_RE),
        .mem_WE    (mem_WE),
        .mem_A     (mem_A),
        .mem_WD    (mem_WD),
        .mem_READY (mem_READY),
        .mem_RD    (mem_RD)
    );

    // ---------------- backing memory (4 KB, word addressed) ----------------
    bit          mem_set [1024];
    logic [31:0] mem_w   [1024];

    function automatic logic [31:0] mem_rd(input int i);
        if (mem_set[i]) return mem_w[i];
        if (i == 16) return 32'hDEAD_BEEF;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        int b;
        b = int'({a[11:4], 2'b00});
        return {mem_rd(b + 3), mem_rd(b + 2), mem_rd(b + 1), mem_rd(b)};
    endfunction

    // ---------------- cache model ----------------
    bit   [63:0]  m_valid = '0;
    logic [21:0]  m_tag  [64];
    logic [31:0]  m_line [64][4];
    bit           m_pending = 1'b0;
    logic [31:0]  m_addr = '0;
    int           m_age = 0;

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid   <= '0;
            m_pending <= 1'b0;
            m_age     <= 0;
        end else if (!m_pending) begin
            if (WriteM) begin
                mem_w[AddrM[11:2]]   <= WDataM;
                mem_set[AddrM[11:2]] <= 1'b1;
                if (m_hit(AddrM)) m_line[AddrM[9:4]][AddrM[3:2]] <= WDataM;
            end else if (ReadM && !m_hit(AddrM)) begin
                m_pending <= 1'b1;
                m_addr    <= AddrM;
                m_age     <= 0;
            end
        end else begin
            // the first cycle after the miss is the request cycle: READY ignored
            if (m_age >= 1 && mem_READY) begin
                m_valid[m_addr[9:4]] <= 1'b1;
                m_tag[m_addr[9:4]]   <= m_addr[31:10];
                for (int k = 0; k < 4; k++) m_line[m_addr[9:4]][k] <= mem_RD[32*k +: 32];
                m_pending <= 1'b0;
            end
            m_age <= m_age + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] e_rd, e_a, e_wd;
    logic        e_st, e_re, e_we;

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_pending) begin
                e_st = 1'b1; e_re = 1'b1; e_we = 1'b0;
                e_rd = '0;   e_wd = '0;
                e_a  = {m_addr[31:4], 4'h0};
            end else begin
                e_re = 1'b0;
                e_we = WriteM;
                e_a  = WriteM ? AddrM  : 32'h0;
                e_wd = WriteM ? WDataM : 32'h0;
                e_st = ReadM && !WriteM && !m_hit(AddrM);
                e_rd = (ReadM && !WriteM && m_hit(AddrM)) ? m_line[AddrM[9:4]][AddrM[3:2]] : 32'h0;
            end
            chk("model StallM", 32'(StallM), 32'(e_st));
            chk("model mem_RE", 32'(mem_RE), 32'(e_re));
            chk("model mem_WE", 32'(mem_WE), 32'(e_we));
            chk("model mem_A",  mem_A,  e_a);
            chk("model mem_WD", mem_WD, e_wd);
            chk("model RDataM", RDataM, e_rd);
        end
    end

    always @(negedge clk) begin
        assert (!(ReadM && WriteM)) else $error("FAIL illegal ReadM and WriteM together");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic load_hit(input logic [31:0] a, input logic [31:0] exp, input string name);
        ReadM = 1'b1; WriteM = 1'b0; AddrM = a;
        at_neg();
        chk({name, " stall"},  32'(StallM), 32'd0);
        chk({name, " data"},   RDataM,      exp);
        chk({name, " mem_RE"}, 32'(mem_RE), 32'd0);
        cyc();
        ReadM = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input string name);
        ReadM = 1'b0; WriteM = 1'b1; AddrM = a; WDataM = d;
        at_neg();
        chk({name, " mem_WE"}, 32'(mem_WE), 32'd1);
        chk({name, " mem_A"},  mem_A,       a);
        chk({name, " mem_WD"}, mem_WD,      d);
        chk({name, " stall"},  32'(StallM), 32'd0);
        cyc();
        WriteM = 1'b0; WDataM = '0;
    endtask

    task automatic load_miss(input logic [31:0] a, input logic [31:0] exp, input string name);
        ReadM = 1'b1; WriteM = 1'b0; AddrM = a;
        at_neg();
        chk({name, " detect stall"},  32'(StallM), 32'd1);
        chk({name, " detect mem_RE"}, 32'(mem_RE), 32'd0);
        cyc();
        at_neg();
        chk({name, " req mem_RE"}, 32'(mem_RE), 32'd1);
        chk({name, " req mem_A"},  mem_A,       {a[31:4], 4'h0});
        cyc();
        repeat (17) cyc();
        mem_READY = 1'b1; mem_RD = line_of(a);
        cyc();
        mem_READY = 1'b0; mem_RD = '0;
        at_neg();
        chk({name, " replay stall"}, 32'(StallM), 32'd0);
        chk({name, " replay data"},  RDataM,      exp);
        cyc();
        ReadM = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1; ReadM = 1'b0; WriteM = 1'b0; AddrM = '0; WDataM = '0;
        mem_READY = 1'b0; mem_RD = '0;
        cyc();
        chk_en = 1'b1;
        at_neg();
        chk("reset StallM", 32'(StallM), 32'd0);
        chk("reset mem_RE", 32'(mem_RE), 32'd0);
        chk("reset mem_WE", 32'(mem_WE), 32'd0);
        chk("reset mem_A",  mem_A,       32'd0);
        chk("reset mem_WD", mem_WD,      32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // 1: cold load miss
        load_miss(32'h0000_0040, 32'hDEAD_BEEF, "cold");
        // 2: same-line hit, word 3
        load_hit(32'h0000_004C, mem_rd(32'h13), "sameline");
        // 3: store hit then load
        store(32'h0000_0044, 32'h1234_5678, "sthit");
        load_hit(32'h0000_0044, 32'h1234_5678, "sthit load");
        // 4: store miss, no allocate, then load fills the written value
        store(32'h0000_0800, 32'hCAFE_0000, "stmiss");
        load_miss(32'h0000_0800, 32'hCAFE_0000, "stmiss load");
        // 5: conflict eviction on index 4
        load_hit(32'h0000_0040, 32'hDEAD_BEEF, "evict pre");
        load_miss(32'h0000_0440, mem_rd(32'h110), "evict new");
        load_miss(32'h0000_0040, 32'hDEAD_BEEF, "evict back");
        load_hit(32'h0000_0044, 32'h1234_5678, "evict back w1");

        // 6: stale READY in REQ, then reset in the tenth FILL cycle
        ReadM = 1'b1; AddrM = 32'h0000_0900;
        at_neg();
        chk("rstfill detect stall", 32'(StallM), 32'd1);
        cyc();
        mem_READY = 1'b1; mem_RD = {4{32'hBAD0_BAD0}};
        at_neg();
        chk("stale req mem_RE", 32'(mem_RE), 32'd1);
        cyc();
        mem_READY = 1'b0; mem_RD = '0;
        at_neg();
        chk("stale fill mem_RE", 32'(mem_RE), 32'd1);
        chk("stale fill stall",  32'(StallM), 32'd1);
        repeat (9) cyc();
        rst = 1'b1; ReadM = 1'b0;
        cyc();
        rst = 1'b0;
        at_neg();
        chk("rstfill mem_RE", 32'(mem_RE), 32'd0);
        chk("rstfill stall",  32'(StallM), 32'd0);
        chk("rstfill mem_A",  mem_A,       32'd0);
        cyc();
        load_miss(32'h0000_0900, mem_rd(32'h240), "rstfill reload");
        load_miss(32'h0000_0040, 32'hDEAD_BEEF, "post reset cold");

        repeat (3) cyc();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
